rcc_bdcr_ctrl: RTL

Clocked, parametrised successor of the backup-domain control register (BDCR) for the RCC. It holds the LSE oscillator controls, the write-once RTC clock selection, the RTC enable and the backup-domain software reset. It adds three things: a write-protect gate, an LSE ready synchroniser, and an LSE supervisor FSM (startup timeout plus clock-security failure detection). It sits between the RCC register bus decode and the LSE analog/RTC clock mux.

---
 rtl/rcc_bdcr_ctrl_pkg.sv | 26 ++
 rtl/rcc_bdcr_ctrl_sync_nff.sv | 29 ++
 rtl/rcc_bdcr_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/rcc_bdcr_ctrl_pkg.sv
// Shared RCC definitions for the backup-domain control register.
// Holds the field bit positions, the readback mask and the LSE supervisor states.
package rcc_bdcr_ctrl_pkg;

   localparam int LSEON_BIT    = 0;
   localparam int LSERDY_BIT   = 1;
   localparam int LSEBYP_BIT   = 2;
   localparam int LSEDRV_LSB   = 3;
   localparam int LSECSSON_BIT = 5;
   localparam int LSECSSD_BIT  = 6;
   localparam int LSETMO_BIT   = 7;
   localparam int RTCSEL_LSB   = 8;
   localparam int RTCEN_BIT    = 15;
   localparam int BDRST_BIT    = 16;

   localparam logic [31:0] BDCR_MASK = 32'h0001_83FF;

   typedef enum logic [2:0] {
      LSE_OFF   = 3'd0,
      LSE_START = 3'd1,
      LSE_RUN   = 3'd2,
      LSE_FAIL  = 3'd3,
      LSE_TMO   = 3'd4
   } lse_state_e;

endpackage

// File: rtl/rcc_bdcr_ctrl_sync_nff.sv
// N-flop synchroniser with asynchronous active-high reset.
// Reusable for any asynchronous RCC oscillator ready input.
module rcc_sync_nff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rcc_bdcr_ctrl.sv
// Backup-domain control register: LSE controls, write-once RTC clock select,
// write-protect gate, LSE ready synchroniser and LSE startup/CSS supervisor.
module rcc_bdcr_ctrl
   import rcc_bdcr_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dbp,
   input  logic        wr_en,
   input  logic [3:0]  wr_be,
   input  logic [31:0] wr_data,
   output logic        wr_err,
   output logic [31:0] rd_data,
   input  logic        lserdy_async,
   output logic        lseon,
   output logic        lsebyp,
   output logic        lsecsson,
   output logic        rtcen,
   output logic        bdrst,
   output logic [1:0]  lsedrv,
   output logic [1:0]  rtcsel,
   output logic        css_irq
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

   lse_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic lseon_q, lseon_d;
   logic lsebyp_q, lsebyp_d;
   logic [1:0] lsedrv_q, lsedrv_d;
   logic lsecsson_q, lsecsson_d;
   logic lsecssd_q, lsecssd_d;
   logic lsetmo_q, lsetmo_d;
   logic [1:0] rtcsel_q, rtcsel_d;
   logic rtcsel_lock_q, rtcsel_lock_d;
   logic rtcen_q, rtcen_d;
   logic bdrst_q, bdrst_d;
   logic wr_err_q, wr_err_d;
   logic css_irq_q, css_irq_d;
   logic lserdy_sync;
   logic wr_ok;
   logic css_fail;
   logic tmo_set;
   logic unused_wr_bits;

   assign unused_wr_bits = ^{wr_be[3], wr_data[31:17], wr_data[14:10], wr_data[7:6], wr_data[1]};

   rcc_sync_nff #(
      .STAGES (SYNC_STAGES)
   ) u_lserdy_sync (
      .clk (clk),
      .rst (rst),
      .d   (lserdy_async),
      .q   (lserdy_sync)
   );

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      lseon_d       = lseon_q;
      lsebyp_d      = lsebyp_q;
      lsedrv_d      = lsedrv_q;
      lsecsson_d    = lsecsson_q;
      lsecssd_d     = lsecssd_q;
      lsetmo_d      = lsetmo_q;
      rtcsel_d      = rtcsel_q;
      rtcsel_lock_d = rtcsel_lock_q;
      rtcen_d       = rtcen_q;
      bdrst_d       = bdrst_q;
      wr_ok         = wr_en & dbp;
      wr_err_d      = wr_en & ~dbp;
      css_irq_d     = 1'b0;
      css_fail      = 1'b0;
      tmo_set       = 1'b0;

      case (state_q)
         LSE_OFF: begin
            cnt_d = '0;
            if (lseon_q) begin
               state_d = LSE_START;
            end
         end
         LSE_START: begin
            if (lserdy_sync) begin
               state_d = LSE_RUN;
            end else if (cnt_q == CNT_LAST) begin
               state_d = LSE_TMO;
               tmo_set = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LSE_RUN: begin
            if (!lserdy_sync) begin
               if (lsecsson_q) begin
                  state_d  = LSE_FAIL;
                  css_fail = 1'b1;
               end else begin
                  state_d = LSE_START;
                  cnt_d   = '0;
               end
            end
         end
         LSE_FAIL, LSE_TMO: begin
            state_d = state_q;
         end
         default: begin
            state_d = LSE_OFF;
            cnt_d   = '0;
         end
      endcase

      // Switching the oscillator off overrides any transition, but a CSS hit
      // seen in the same cycle is still reported through css_fail below.
      if (!lseon_q) begin
         state_d = LSE_OFF;
         cnt_d   = '0;
      end

      if (wr_ok && wr_be[2]) begin
         bdrst_d = wr_data[BDRST_BIT];
      end else if (wr_ok && !bdrst_q) begin
         if (wr_be[0]) begin
            lseon_d = wr_data[LSEON_BIT];
            if (state_q == LSE_OFF && !lseon_q) begin
               lsebyp_d = wr_data[LSEBYP_BIT];
               lsedrv_d = wr_data[LSEDRV_LSB +: 2];
            end
            if (wr_data[LSECSSON_BIT]) begin
               lsecsson_d = 1'b1;
            end
         end
         if (wr_be[1]) begin
            rtcen_d = wr_data[RTCEN_BIT];
            if (!rtcsel_lock_q) begin
               rtcsel_d = wr_data[RTCSEL_LSB +: 2];
               if (wr_data[RTCSEL_LSB +: 2] != 2'b00) begin
                  rtcsel_lock_d = 1'b1;
               end
            end
         end
      end

      // The failure unlocks rtcsel after the write was judged against the old lock.
      if (css_fail) begin
         lsecssd_d     = 1'b1;
         css_irq_d     = 1'b1;
         lsecsson_d    = 1'b0;
         rtcsel_lock_d = 1'b0;
      end
      if (tmo_set) begin
         lsetmo_d = 1'b1;
      end

      if (bdrst_d) begin
         state_d       = LSE_OFF;
         cnt_d         = '0;
         lseon_d       = 1'b0;
         lsebyp_d      = 1'b0;
         lsedrv_d      = 2'b00;
         lsecsson_d    = 1'b0;
         lsecssd_d     = 1'b0;
         lsetmo_d      = 1'b0;
         rtcsel_d      = 2'b00;
         rtcsel_lock_d = 1'b0;
         rtcen_d       = 1'b0;
         css_irq_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= LSE_OFF;
         cnt_q         <= '0;
         lseon_q       <= 1'b0;
         lsebyp_q      <= 1'b0;
         lsedrv_q      <= 2'b00;
         lsecsson_q    <= 1'b0;
         lsecssd_q     <= 1'b0;
         lsetmo_q      <= 1'b0;
         rtcsel_q      <= 2'b00;
         rtcsel_lock_q <= 1'b0;
         rtcen_q       <= 1'b0;
         bdrst_q       <= 1'b0;
         wr_err_q      <= 1'b0;
         css_irq_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         lseon_q       <= lseon_d;
         lsebyp_q      <= lsebyp_d;
         lsedrv_q      <= lsedrv_d;
         lsecsson_q    <= lsecsson_d;
         lsecssd_q     <= lsecssd_d;
         lsetmo_q      <= lsetmo_d;
         rtcsel_q      <= rtcsel_d;
         rtcsel_lock_q <= rtcsel_lock_d;
         rtcen_q       <= rtcen_d;
         bdrst_q       <= bdrst_d;
         wr_err_q      <= wr_err_d;
         css_irq_q     <= css_irq_d;
      end
   end

   always_comb begin
      rd_data                      = '0;
      rd_data[LSEON_BIT]           = lseon_q;
      rd_data[LSERDY_BIT]          = lserdy_sync & (state_q == LSE_RUN);
      rd_data[LSEBYP_BIT]          = lsebyp_q;
      rd_data[LSEDRV_LSB +: 2]     = lsedrv_q;
      rd_data[LSECSSON_BIT]        = lsecsson_q;
      rd_data[LSECSSD_BIT]         = lsecssd_q;
      rd_data[LSETMO_BIT]          = lsetmo_q;
      rd_data[RTCSEL_LSB +: 2]     = rtcsel_q;
      rd_data[RTCEN_BIT]           = rtcen_q;
      rd_data[BDRST_BIT]           = bdrst_q;
      rd_data                      = rd_data & BDCR_MASK;
   end

   assign lseon    = lseon_q;
   assign lsebyp   = lsebyp_q;
   assign lsedrv   = lsedrv_q;
   assign lsecsson = lsecsson_q;
   assign rtcsel   = rtcsel_q;
   assign rtcen    = rtcen_q;
   assign bdrst    = bdrst_q;
   assign wr_err   = wr_err_q;
   assign css_irq  = css_irq_q;

endmodule
